// File: rtl/load_store_unit.sv
// RV32I load/store unit for a word-only data memory: range/alignment checks, load extension and
// read-modify-write for SB/SH. Optional macro LSU_FAST_LOAD_EN completes legal loads from IDLE.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 33
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_mem_we,
    output logic [31:0] o_mem_a,
    output logic [31:0] o_mem_wd,
    input  logic [31:0] i_mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t      r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lo;
    logic [31:0] r_wdata;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_a;
    logic [31:0] r_mem_wd;

    logic        w_req_err;
    logic [31:0] w_word_a;

    function automatic logic f_req_err(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        logic misal;
        logic oor;
        case (f3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !wr;
            default:                legal = 1'b0;
        endcase
        misal = ((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        oor   = ({2'b00, addr[31:2]} >= MEM_WORDS);
        return !legal || misal || oor;
    endfunction

    function automatic logic [31:0] f_load_ext(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    // Only the addressed lane of the old word is replaced; the rest is written back unchanged.
    function automatic logic [31:0] f_merge(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] m;
        m = old;
        case (f3[1:0])
            2'b00: m[{lo, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lo[1]) m[31:16] = wd[15:0];
                else       m[15:0]  = wd[15:0];
            end
            default: m = wd;
        endcase
        return m;
    endfunction

    assign w_req_err = f_req_err(i_wr, i_funct3, i_addr);
    assign w_word_a  = {i_addr[31:2], 2'b00};

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_err    = r_err;
    assign o_rdata  = r_rdata;
    assign o_mem_wd = r_mem_wd;
    // Reset asserted during WRITE must suppress the memory write in that same cycle.
    assign o_mem_we = (r_state == S_WRITE) && i_rst_n;
`ifdef LSU_FAST_LOAD_EN
    assign o_mem_a  = (r_state == S_IDLE) ? w_word_a : r_mem_a;
`else
    assign o_mem_a  = r_mem_a;
`endif

    // Request FSM with registered status, data and memory-side outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_funct3 <= 3'd0;
            r_lo     <= 2'd0;
            r_wdata  <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
            r_mem_a  <= 32'd0;
            r_mem_wd <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (i_req) begin
                        r_funct3 <= i_funct3;
                        r_lo     <= i_addr[1:0];
                        r_wdata  <= i_wdata;
                        r_busy   <= 1'b1;
                        if (w_req_err) begin
                            r_state <= S_RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (!i_wr) begin
                            r_mem_a <= w_word_a;
`ifdef LSU_FAST_LOAD_EN
                            r_rdata <= f_load_ext(i_funct3, i_addr[1:0], i_mem_rd);
                            r_state <= S_RESP;
                            r_done  <= 1'b1;
`else
                            r_state <= S_LOAD;
`endif
                        end else if (i_funct3[1:0] == 2'b10) begin
                            r_mem_a  <= w_word_a;
                            r_mem_wd <= i_wdata;
                            r_state  <= S_WRITE;
                        end else begin
                            r_mem_a <= w_word_a;
                            r_state <= S_RMW_RD;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_rdata <= f_load_ext(r_funct3, r_lo, i_mem_rd);
                    r_state <= S_RESP;
                    r_done  <= 1'b1;
                end
                S_RMW_RD: begin
                    r_mem_wd <= f_merge(r_funct3, r_lo, i_mem_rd, r_wdata);
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    r_state <= S_RESP;
                    r_done  <= 1'b1;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
`ifdef LSU_FAST_LOAD_EN
    localparam int LLAT = 1;
`else
    localparam int LLAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, err, mem_we;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:32];
    logic        pl_we = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'd0;
    logic [29:0] mem_idx;

    int checks = 0;
    int errors = 0;

    load_store_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wr(wr), .i_funct3(f3),
        .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_err(err),
        .o_rdata(rdata), .o_mem_we(mem_we), .o_mem_a(mem_a), .o_mem_wd(mem_wd),
        .i_mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_idx = mem_a[31:2];
    assign mem_rd  = (mem_idx < 30'd33) ? mem[mem_idx[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_data;
        else if (mem_we && (mem_idx < 30'd33)) mem[mem_idx[5:0]] <= mem_wd;
    end

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pl;
        logic [31:0] pl_word;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        int          cyc;
        int          we;
        logic        chk_mem;
        logic [31:0] mem_val;
    } vec_t;

    vec_t v [18];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = idx[5:0]; pl_data = d;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    task automatic do_op(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                         output int cyc, output int we_cnt, output logic e);
        @(negedge clk);
        req = 1'b1; wr = w; f3 = f; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0; wr = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        cyc = 0; we_cnt = 0; e = 1'bx;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (done) begin
                cyc = k; e = err;
                break;
            end
        end
    endtask

    initial begin
        int   cyc, wec, ndone;
        logic e;

        v[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        2,    1, 1'b1, 32'hDEADBEEF};
        v[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, LLAT, 0, 1'b0, 32'h0};
        v[2]  = '{1'b1, 3'b000, 32'h11, 32'hFFFFFF5A, 1'b1, 32'h11223344, 1'b0, 1'b0, 32'h0,        3,    1, 1'b1, 32'h11225A44};
        v[3]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h11225A44, LLAT, 0, 1'b0, 32'h0};
        v[4]  = '{1'b0, 3'b000, 32'h13, 32'h0,        1'b1, 32'h80FF0000, 1'b0, 1'b1, 32'hFFFFFF80, LLAT, 0, 1'b0, 32'h0};
        v[5]  = '{1'b0, 3'b100, 32'h13, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h00000080, LLAT, 0, 1'b0, 32'h0};
        v[6]  = '{1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF80FF, LLAT, 0, 1'b0, 32'h0};
        v[7]  = '{1'b0, 3'b101, 32'h12, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h000080FF, LLAT, 0, 1'b0, 32'h0};
        v[8]  = '{1'b1, 3'b001, 32'h12, 32'h1234BEEF, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        3,    1, 1'b1, 32'hBEEF0000};
        v[9]  = '{1'b0, 3'b000, 32'h11, 32'h0,        1'b1, 32'h00007F00, 1'b0, 1'b1, 32'h0000007F, LLAT, 0, 1'b0, 32'h0};
        v[10] = '{1'b1, 3'b010, 32'h80, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        2,    1, 1'b1, 32'hCAFEF00D};
        v[11] = '{1'b0, 3'b010, 32'h80, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D, LLAT, 0, 1'b0, 32'h0};
        v[12] = '{1'b0, 3'b001, 32'h01, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'hCAFEF00D, 1,    0, 1'b0, 32'h0};
        v[13] = '{1'b0, 3'b010, 32'h82, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'hCAFEF00D, 1,    0, 1'b0, 32'h0};
        v[14] = '{1'b0, 3'b010, 32'h84, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'hCAFEF00D, 1,    0, 1'b0, 32'h0};
        v[15] = '{1'b0, 3'b011, 32'h10, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'hCAFEF00D, 1,    0, 1'b0, 32'h0};
        v[16] = '{1'b1, 3'b100, 32'h10, 32'h77777777, 1'b0, 32'h0,        1'b1, 1'b1, 32'hCAFEF00D, 1,    0, 1'b0, 32'h0};
        v[17] = '{1'b1, 3'b000, 32'h84, 32'h000000AA, 1'b0, 32'h0,        1'b1, 1'b1, 32'hCAFEF00D, 1,    0, 1'b0, 32'h0};

        // Reset for two cycles, then every output must read zero.
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk32("rst_busy",  {31'd0, busy},   32'd0);
        chk32("rst_done",  {31'd0, done},   32'd0);
        chk32("rst_err",   {31'd0, err},    32'd0);
        chk32("rst_rdata", rdata,           32'd0);
        chk32("rst_we",    {31'd0, mem_we}, 32'd0);
        chk32("rst_mem_a", mem_a,           32'd0);
        chk32("rst_wd",    mem_wd,          32'd0);

        for (int i = 0; i < 18; i++) begin
            if (v[i].pl) preload(int'(v[i].addr[31:2]), v[i].pl_word);
            do_op(v[i].wr, v[i].f3, v[i].addr, v[i].wdata, cyc, wec, e);
            chk32($sformatf("v%0d_cyc", i), 32'(cyc), 32'(v[i].cyc));
            chk32($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, v[i].err});
            chk32($sformatf("v%0d_we", i), 32'(wec), 32'(v[i].we));
            if (v[i].chk_rd) chk32($sformatf("v%0d_rdata", i), rdata, v[i].rdata);
            if (v[i].chk_mem) chk32($sformatf("v%0d_mem", i), mem[v[i].addr[7:2]], v[i].mem_val);
        end

        // A second request while busy is dropped, not queued.
        preload(6, 32'h0);
        preload(7, 32'h0);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; f3 = 3'b010; addr = 32'h18; wdata = 32'h01010101;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk32("busy_high", {31'd0, busy}, 32'd1);
        req = 1'b1; addr = 32'h1C; wdata = 32'h02020202;
        @(posedge clk);
        #1 req = 1'b0; wr = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk32("busy_ndone", 32'(ndone), 32'd1);
        chk32("busy_mem6", mem[6], 32'h01010101);
        chk32("busy_mem7", mem[7], 32'h0);

        // Reset during the WRITE cycle of an SH: no write, no DONE, outputs back to zero.
        preload(5, 32'h55667788);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; f3 = 3'b001; addr = 32'h14; wdata = 32'h0000AAAA;
        @(posedge clk);
        #1 req = 1'b0; wr = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk32("rmw_we_before", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1 chk32("rmw_we_gated", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk32("mid_busy",  {31'd0, busy}, 32'd0);
        chk32("mid_done",  {31'd0, done}, 32'd0);
        chk32("mid_rdata", rdata,         32'd0);
        chk32("mid_mem_a", mem_a,         32'd0);
        chk32("mid_wd",    mem_wd,        32'd0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk32("mid_ndone", 32'(ndone), 32'd0);
        chk32("mid_mem5", mem[5], 32'h55667788);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
